acq_sequencer: RTL
==================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous, active-high reset.
REQ-002 The block SHALL have these control inputs: start  in  1  single-cycle run request; abort  in  1  single-cycle cancel request.
REQ-003 The block SHALL have these configuration inputs: cfg_samples  in  24  samples per repetition minus 1; cfg_reps  in  24  repetition count; cfg_timeout  in  32  inter-write watchdog limit in clk cycles, 0 = disabled.
REQ-004 The block SHALL have these monitor inputs from the acquisition FSM: fsm_write_enable  in  1; fsm_write_address  in  32.
REQ-005 The block SHALL have these outputs to the acquisition FSM: sniff_trig  out  1  arm pulse; max_sample_cnt  out  24; max_repetition_cnt  out  24.
REQ-006 The block SHALL have these status outputs: busy  out  1; done  out  1 (sticky); aborted  out  1 (sticky); err_timeout  out  1 (sticky); words_written  out  32; last_address  out  32.

Function
REQ-007 The state machine SHALL have the states IDLE, ARM, RUN and FINISH.
REQ-008 In IDLE, when start=1 and cfg_reps!=0, the block SHALL latch cfg_samples into max_sample_cnt and cfg_reps into max_repetition_cnt, clear done, aborted, err_timeout and words_written, and go to ARM on the next edge.
REQ-009 In IDLE, when start=1 and cfg_reps==0, the block SHALL go straight to FINISH without asserting sniff_trig.
REQ-010 In ARM, the block SHALL assert sniff_trig for exactly one cycle and then go to RUN; sniff_trig SHALL be 0 in every other state.
REQ-011 In RUN, every cycle with fsm_write_enable=1 SHALL increment words_written (32-bit, wraps modulo 2^32) and register fsm_write_address into last_address.
REQ-012 In RUN, an internal 24-bit sample counter SHALL count write cycles. On reaching max_sample_cnt+1 it SHALL reset to 0 and increment a 24-bit repetition counter.
REQ-013 RUN SHALL go to FINISH in the same cycle the repetition counter reaches max_repetition_cnt.
REQ-014 In FINISH, the block SHALL set done=1 and go to IDLE after one cycle.
REQ-015 busy SHALL be 1 in ARM, RUN and FINISH, and 0 in IDLE.
REQ-016 The watchdog SHALL be cleared on entry to RUN and on every write cycle, and SHALL increment every other RUN cycle. When cfg_timeout!=0 and the watchdog equals cfg_timeout, the block SHALL set err_timeout=1 and go to IDLE without setting done.
REQ-017 A start that arrives while busy=1 SHALL be ignored.
REQ-018 An abort in ARM or RUN SHALL move the block to IDLE on the next edge and set aborted=1; sniff_trig SHALL NOT fire that cycle; abort in IDLE or FINISH SHALL be ignored.
REQ-019 When abort and a completion or timeout occur in the same cycle, abort SHALL win.
REQ-020 max_sample_cnt and max_repetition_cnt SHALL remain stable from the start edge until the next accepted start.
REQ-021 Changes to cfg_* while busy=1 SHALL have no effect on the run in progress.

Reset
REQ-022 While rst=1, the block SHALL force state=IDLE and drive every output to 0, including the counters and the latched configuration.
REQ-023 A reset asserted in the middle of a run SHALL discard all progress; no done pulse SHALL follow the release of reset.

Structure
REQ-024 A shared package acq_pkg SHALL hold the state encoding, the width constants (SAMPLE_W=24, ADDR_W=32, TIMEOUT_W=32) and the address stride constant (4).
REQ-025 The watchdog SHALL be one sub-module, acq_watchdog, with inputs clk, rst, clear, enable and limit, and output expired.

Verification
REQ-026 Nominal run: cfg_samples=3, cfg_reps=2, start; one sniff_trig pulse; 8 write cycles -> done=1, words_written=8, last_address=0x1C, busy=0.
REQ-027 Zero repetitions: cfg_reps=0, start -> sniff_trig stays 0; done=1 two cycles later; words_written=0.
REQ-028 Timeout: cfg_timeout=10, start, no writes -> err_timeout=1 after 10 RUN cycles; done=0; state IDLE.
REQ-029 Abort: cfg_samples=3, cfg_reps=2, abort after 5 writes -> aborted=1, words_written=5, done=0; a second abort in IDLE has no effect.
REQ-030 Start while busy: a second start and a change to cfg_samples=7 during RUN -> no re-arm; max_sample_cnt stays 3.
REQ-031 Mid-run reset: rst pulsed during RUN -> all outputs 0 immediately; a new start then completes normally.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: state encoding,
// datapath widths and the address stride of the acquisition FSM writes.
package acq_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int ADDR_W    = 32;
    localparam int TIMEOUT_W = 32;
    localparam int WORD_W    = 32;

    // Byte distance between consecutive acquisition writes.
    localparam logic [ADDR_W-1:0] ADDR_STRIDE = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } acq_state_e;

endpackage

// File: rtl/acq_watchdog.sv
// Inter-write watchdog: counts cycles while enabled, restarts on clear,
// and flags expiry when the count equals a non-zero limit.
module acq_watchdog
    import acq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] count_reg;

    // Cycle counter; clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + TIMEOUT_W'(1);
        end
    end

    // A limit of zero disables the watchdog entirely.
    assign expired = (limit != '0) && (count_reg == limit);

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms the acquisition FSM, tracks its writes into
// samples and repetitions, and reports completion, abort and watchdog errors.
module acq_sequencer
    import acq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SAMPLE_W-1:0]  cfg_samples,
    input  logic [SAMPLE_W-1:0]  cfg_reps,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 fsm_write_enable,
    input  logic [ADDR_W-1:0]    fsm_write_address,
    output logic                 sniff_trig,
    output logic [SAMPLE_W-1:0]  max_sample_cnt,
    output logic [SAMPLE_W-1:0]  max_repetition_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 err_timeout,
    output logic [WORD_W-1:0]    words_written,
    output logic [ADDR_W-1:0]    last_address
);

    acq_state_e            state_reg;
    logic [SAMPLE_W-1:0]   max_sample_reg;
    logic [SAMPLE_W-1:0]   max_rep_reg;
    logic [TIMEOUT_W-1:0]  timeout_reg;
    logic [SAMPLE_W-1:0]   sample_cnt_reg;
    logic [SAMPLE_W-1:0]   rep_cnt_reg;
    logic                  sniff_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  aborted_reg;
    logic                  err_reg;
    logic [WORD_W-1:0]     words_reg;
    logic [ADDR_W-1:0]     last_addr_reg;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    // The watchdog only runs in RUN; outside RUN it is held clear so that
    // it always starts from zero on entry, and each write restarts it.
    assign wd_clear  = (state_reg != ST_RUN) || fsm_write_enable;
    assign wd_enable = (state_reg == ST_RUN);

    acq_watchdog u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (timeout_reg),
        .expired (wd_expired)
    );

    // Sequencer FSM with all status outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            max_sample_reg <= '0;
            max_rep_reg    <= '0;
            timeout_reg    <= '0;
            sample_cnt_reg <= '0;
            rep_cnt_reg    <= '0;
            sniff_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
            err_reg        <= 1'b0;
            words_reg      <= '0;
            last_addr_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    sniff_reg <= 1'b0;
                    if (start) begin
                        // Configuration is captured here so later cfg_*
                        // changes cannot disturb the run in progress.
                        max_sample_reg <= cfg_samples;
                        max_rep_reg    <= cfg_reps;
                        timeout_reg    <= cfg_timeout;
                        sample_cnt_reg <= '0;
                        rep_cnt_reg    <= '0;
                        done_reg       <= 1'b0;
                        aborted_reg    <= 1'b0;
                        err_reg        <= 1'b0;
                        words_reg      <= '0;
                        busy_reg       <= 1'b1;
                        if (cfg_reps != '0) begin
                            state_reg <= ST_ARM;
                            sniff_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_FINISH;
                        end
                    end
                end

                ST_ARM: begin
                    sniff_reg <= 1'b0;
                    if (abort) begin
                        state_reg   <= ST_IDLE;
                        aborted_reg <= 1'b1;
                        busy_reg    <= 1'b0;
                    end else begin
                        state_reg <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    // Abort outranks a watchdog expiry, which outranks the
                    // write that would otherwise complete the run.
                    if (abort) begin
                        state_reg   <= ST_IDLE;
                        aborted_reg <= 1'b1;
                        busy_reg    <= 1'b0;
                    end else if (wd_expired) begin
                        state_reg <= ST_IDLE;
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else if (fsm_write_enable) begin
                        words_reg     <= words_reg + WORD_W'(1);
                        last_addr_reg <= fsm_write_address;
                        // Comparing against max (not max+1) avoids overflow
                        // when max_sample_cnt is all ones.
                        if (sample_cnt_reg == max_sample_reg) begin
                            sample_cnt_reg <= '0;
                            rep_cnt_reg    <= rep_cnt_reg + SAMPLE_W'(1);
                            if ((rep_cnt_reg + SAMPLE_W'(1)) == max_rep_reg) begin
                                state_reg <= ST_FINISH;
                            end
                        end else begin
                            sample_cnt_reg <= sample_cnt_reg + SAMPLE_W'(1);
                        end
                    end
                end

                ST_FINISH: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    sniff_reg <= 1'b0;
                end
            endcase
        end
    end

    // The arm pulse is suppressed combinationally by an abort in the same
    // ARM cycle, so a cancelled run never triggers the acquisition FSM.
    assign sniff_trig         = sniff_reg & ~abort;
    assign max_sample_cnt     = max_sample_reg;
    assign max_repetition_cnt = max_rep_reg;
    assign busy               = busy_reg;
    assign done               = done_reg;
    assign aborted            = aborted_reg;
    assign err_timeout        = err_reg;
    assign words_written      = words_reg;
    assign last_address       = last_addr_reg;

endmodule
